mliu_wb_buffer: RTL and testbench



---
 rtl/mliu_wb_buffer.sv | 228 ++++++++++++++++++++++
 tb/tb_mliu_wb_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mliu_wb_buffer.sv
// mliu_wb_buffer: writeback buffer that sits directly behind the ML inference unit (MLIU).
//
// Every MLIU response is captured into a small FIFO, because the MLIU output cannot be
// back-pressured. The head entry is offered to the integer register-file writeback port
// with a valid/ready handshake. Requests in flight inside the MLIU are tracked, and an
// issue credit is granted only while every outstanding request is guaranteed a FIFO slot.
//
// Ports:
//   clk_i            clock; all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   issue_fire_i     an MLIU request was accepted this cycle
//   issue_credit_o   upstream may fire a new MLIU request this cycle
//   mliu_rsp_i       MLIU response {valid, rd_addr, error, data}
//   wb_valid_o       head entry is valid
//   wb_rd_addr_o     head destination register (0 when empty)
//   wb_data_o        head result (0 when empty)
//   wb_error_o       head carries an MLIU error (0 when empty)
//   wb_ready_i       consumer accepts the head
//   in_flight_o      requests issued but not yet returned
//   count_o          FIFO occupancy
//   overflow_o       sticky: a response was dropped because the FIFO was full
//   err_cnt_o        saturating count of enqueued error responses

package mliu_wb_pkg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic        error;
    logic [31:0] data;
  } mliu_rsp_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic        error;
    logic [31:0] data;
  } wb_entry_t;

endpackage

module mliu_wb_buffer
  import mliu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_fire_i,
  output logic             issue_credit_o,
  input  mliu_rsp_t        mliu_rsp_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_addr_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_error_o,
  input  logic             wb_ready_i,
  output logic [CNT_W-1:0] in_flight_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic [7:0]       err_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Elaboration-time parameter sanity.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mliu_wb_buffer: DEPTH must be a power of two and at least 4");
  end
  if (CNT_W < $clog2(DEPTH) + 1) begin : g_bad_cnt_w
    $error("mliu_wb_buffer: CNT_W too narrow to hold DEPTH");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_entry_t        mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // ---------------------------------------------------------------------------
  // Push / pop decode
  // ---------------------------------------------------------------------------
  logic      rsp_null;
  logic      push_req;
  logic      empty;
  logic      full;
  logic      pop;
  logic      push;
  logic      drop;
  wb_entry_t head;
  wb_entry_t wr_entry;

  always_comb begin
    // A null response (rd x0, no error) has nothing to write back, but it still
    // retires an in-flight request below.
    rsp_null = (mliu_rsp_i.rd_addr == 5'd0) && !mliu_rsp_i.error;
    push_req = mliu_rsp_i.valid && !rsp_null;
    empty    = (count_q == '0);
    full     = (count_q == DepthC);
    pop      = !empty && wb_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    wr_entry.rd_addr = mliu_rsp_i.rd_addr;
    wr_entry.error   = mliu_rsp_i.error;
    wr_entry.data    = mliu_rsp_i.data;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    in_flight_d = in_flight_q;
    overflow_d  = overflow_q | drop;
    err_cnt_d   = err_cnt_q;

    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Issue and return in the same cycle cancel out. A return with nothing in
    // flight is clamped at zero, and an over-issue is clamped at the top.
    unique case ({issue_fire_i, mliu_rsp_i.valid})
      2'b10: begin
        if (in_flight_q != CntMax) begin
          in_flight_d = in_flight_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (in_flight_q != '0) begin
          in_flight_d = in_flight_q - CNT_W'(1);
        end
      end
      default: in_flight_d = in_flight_q;
    endcase

    if (push && mliu_rsp_i.error && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Entry storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] occupancy_sum;

  always_comb begin
    head          = mem_q[rptr_q];
    wb_valid_o    = !empty;
    wb_rd_addr_o  = empty ? 5'd0  : head.rd_addr;
    wb_data_o     = empty ? 32'd0 : head.data;
    wb_error_o    = empty ? 1'b0  : head.error;

    // Credit uses registered state only: every in-flight request plus every
    // queued entry must fit, so the non-stallable MLIU can never overrun us.
    occupancy_sum  = {1'b0, in_flight_q} + {1'b0, count_q};
    issue_credit_o = (occupancy_sum < {1'b0, DepthC});

    in_flight_o   = in_flight_q;
    count_o       = count_q;
    overflow_o    = overflow_q;
    err_cnt_o     = err_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= DepthC);

  a_stall_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (wb_valid_o && !wb_ready_i) |=>
      (wb_valid_o && $stable(wb_rd_addr_o) && $stable(wb_data_o) && $stable(wb_error_o)));

  a_drop_sticky : assert property (@(posedge clk_i) disable iff (rst_i)
    drop |=> overflow_o);

  a_overflow_sticky : assert property (@(posedge clk_i) disable iff (rst_i)
    overflow_o |=> overflow_o);

endmodule

// File: tb/tb_mliu_wb_buffer.sv
// Directed testbench for mliu_wb_buffer (DEPTH = 4).
module tb_mliu_wb_buffer;
  import mliu_wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             issue_fire;
  logic             issue_credit;
  mliu_rsp_t        rsp;
  logic             wb_valid;
  logic [4:0]       wb_rd_addr;
  logic [31:0]      wb_data;
  logic             wb_error;
  logic             wb_ready;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mliu_wb_buffer #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .issue_fire_i  (issue_fire),
    .issue_credit_o(issue_credit),
    .mliu_rsp_i    (rsp),
    .wb_valid_o    (wb_valid),
    .wb_rd_addr_o  (wb_rd_addr),
    .wb_data_o     (wb_data),
    .wb_error_o    (wb_error),
    .wb_ready_i    (wb_ready),
    .in_flight_o   (in_flight),
    .count_o       (count),
    .overflow_o    (overflow),
    .err_cnt_o     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp(input logic [4:0] rd, input logic err, input logic [31:0] d);
    rsp.valid   = 1'b1;
    rsp.rd_addr = rd;
    rsp.error   = err;
    rsp.data    = d;
  endtask

  task automatic idle_rsp();
    rsp = '0;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, ".count"},     32'(count),      32'd0);
    chk({pfx, ".in_flight"}, 32'(in_flight),  32'd0);
    chk({pfx, ".wb_valid"},  32'(wb_valid),   32'd0);
    chk({pfx, ".wb_rd"},     32'(wb_rd_addr), 32'd0);
    chk({pfx, ".wb_data"},   wb_data,         32'd0);
    chk({pfx, ".wb_error"},  32'(wb_error),   32'd0);
    chk({pfx, ".overflow"},  32'(overflow),   32'd0);
    chk({pfx, ".err_cnt"},   32'(err_cnt),    32'd0);
    chk({pfx, ".credit"},    32'(issue_credit), 32'd1);
  endtask

  // Simple 3-stage MLIU model for the credit-fill test.
  logic       pv  [3];
  logic [4:0] prd [3];
  int         accepted;

  initial begin
    rst        = 1'b1;
    issue_fire = 1'b0;
    wb_ready   = 1'b0;
    rsp        = '0;
    #1;

    // Reset values
    tick();
    rst = 1'b0;
    chk_reset("reset");

    // Single op: issue, response 3 cycles later, visible one cycle after capture
    issue_fire = 1'b1;
    tick();
    issue_fire = 1'b0;
    chk("single.in_flight_after_issue", 32'(in_flight), 32'd1);
    tick();
    tick();
    drive_rsp(5'd5, 1'b0, 32'h0000_0011);
    chk("single.no_bypass", 32'(wb_valid), 32'd0);
    tick();
    idle_rsp();
    chk("single.wb_valid", 32'(wb_valid),   32'd1);
    chk("single.wb_rd",    32'(wb_rd_addr), 32'd5);
    chk("single.wb_data",  wb_data,         32'h11);
    chk("single.in_flight", 32'(in_flight), 32'd0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("single.count_after_pop", 32'(count), 32'd0);
    chk("single.valid_after_pop", 32'(wb_valid), 32'd0);
    chk("single.data_zero_empty", wb_data, 32'd0);

    // Credit fill: fire whenever credit allows, consumer stalled
    for (int i = 0; i < 3; i++) begin
      pv[i]  = 1'b0;
      prd[i] = 5'd0;
    end
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      if (pv[2]) drive_rsp(prd[2], 1'b0, 32'(prd[2]) + 32'h100);
      else       idle_rsp();
      issue_fire = issue_credit && (accepted < 8);
      tick();
      pv[2]  = pv[1];
      prd[2] = prd[1];
      pv[1]  = pv[0];
      prd[1] = prd[0];
      pv[0]  = issue_fire;
      prd[0] = 5'(accepted + 1);
      if (issue_fire) accepted++;
    end
    issue_fire = 1'b0;
    idle_rsp();
    chk("fill.accepted",  32'(accepted),     32'd4);
    chk("fill.count",     32'(count),        32'd4);
    chk("fill.in_flight", 32'(in_flight),    32'd0);
    chk("fill.credit",    32'(issue_credit), 32'd0);
    chk("fill.overflow",  32'(overflow),     32'd0);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill.drain_rd%0d", i), 32'(wb_rd_addr), 32'(i + 1));
      tick();
    end
    chk("fill.drained", 32'(count), 32'd0);
    wb_ready = 1'b0;

    // Simultaneous push/pop when full, then push with no pop
    for (int i = 0; i < 4; i++) begin
      drive_rsp(5'(10 + i), 1'b0, 32'h100 + 32'(i));
      tick();
    end
    idle_rsp();
    chk("full.count",  32'(count),        32'd4);
    chk("full.credit", 32'(issue_credit), 32'd0);
    wb_ready = 1'b1;
    drive_rsp(5'd14, 1'b0, 32'h104);
    tick();
    chk("simul.count",    32'(count),      32'd4);
    chk("simul.overflow", 32'(overflow),   32'd0);
    chk("simul.head_rd",  32'(wb_rd_addr), 32'd11);
    wb_ready = 1'b0;
    drive_rsp(5'd15, 1'b0, 32'h105);
    tick();
    idle_rsp();
    chk("drop.overflow",  32'(overflow),   32'd1);
    chk("drop.count",     32'(count),      32'd4);
    chk("drop.head_rd",   32'(wb_rd_addr), 32'd11);
    chk("drop.head_data", wb_data,         32'h101);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drop.drain_rd%0d", i), 32'(wb_rd_addr), 32'(11 + i));
      tick();
    end
    chk("drop.drained", 32'(count), 32'd0);
    wb_ready = 1'b0;

    // Null response and rd=0 error response
    issue_fire = 1'b1;
    tick();
    issue_fire = 1'b0;
    drive_rsp(5'd0, 1'b0, 32'h1234);
    tick();
    idle_rsp();
    chk("null.count",     32'(count),     32'd0);
    chk("null.in_flight", 32'(in_flight), 32'd0);
    drive_rsp(5'd0, 1'b1, 32'hDEAD);
    tick();
    idle_rsp();
    chk("err0.count",    32'(count),      32'd1);
    chk("err0.wb_error", 32'(wb_error),   32'd1);
    chk("err0.wb_rd",    32'(wb_rd_addr), 32'd0);
    chk("err0.wb_data",  wb_data,         32'hDEAD);
    chk("err0.err_cnt",  32'(err_cnt),    32'd1);
    wb_ready = 1'b1;
    tick();
    chk("err0.popped", 32'(count), 32'd0);

    // Wrap-around: 10 entries streamed through a 4-deep FIFO
    for (int i = 0; i < 10; i++) begin
      drive_rsp(5'd3, 1'b0, 32'(i));
      tick();
      chk($sformatf("wrap.data%0d", i), wb_data, 32'(i));
      chk($sformatf("wrap.count%0d", i), 32'(count), 32'd1);
    end
    idle_rsp();
    tick();
    chk("wrap.empty", 32'(count), 32'd0);

    // Error counter saturation (starts at 1, 260 more errors)
    for (int i = 0; i < 260; i++) begin
      drive_rsp(5'd2, 1'b1, 32'(i));
      tick();
    end
    idle_rsp();
    chk("errsat.err_cnt", 32'(err_cnt), 32'd255);
    tick();
    chk("errsat.empty", 32'(count), 32'd0);
    wb_ready = 1'b0;

    // Mid-stream reset: 3 queued, 1 in flight
    for (int i = 0; i < 3; i++) begin
      drive_rsp(5'(20 + i), 1'b0, 32'h200 + 32'(i));
      tick();
    end
    idle_rsp();
    issue_fire = 1'b1;
    tick();
    issue_fire = 1'b0;
    chk("midrst.pre_count",     32'(count),     32'd3);
    chk("midrst.pre_in_flight", 32'(in_flight), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    drive_rsp(5'd7, 1'b0, 32'h77);
    tick();
    idle_rsp();
    chk("midrst.stale_in_flight", 32'(in_flight), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
